aes_stream_packer: RTL and testbench
====================================

# aes_stream_packer

Width converter between the TSE MAC receive stream and the AES datapath. Accepts 32-bit Avalon-ST words, packs four per 128-bit AES block in network order, and zero-pads the final block of a packet. Carries SOP/EOP/empty through and keeps an input-word counter readable over Avalon-MM at the peripheral register map. Sits directly downstream of the MAC RX interface and upstream of the AES core.

## Interface
- `IN_WIDTH`, default `MAC_STREAM_WIDTH` (32): input word width; fixed by the MAC, not to be changed.
- `OUT_WIDTH`, default `AES_DATA_WIDTH` (128): output block width; must be 4×`IN_WIDTH`.
- `CNT_WIDTH`, default `WORD_COUNTER_SIZE` (8): word counter width.
- `CNT_ADDR`, default `PERIPHERAL_ADDR + MSG_WORD_CNT` (`'h1000`): counter register address.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_data` in 32: input word; byte 0 in `[31:24]`.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_sop` in 1: first word of packet.
- `in_eop` in 1: last word of packet.
- `in_empty` in 2: empty low-order bytes in the EOP word.
- `out_data` out 128: packed block; first word in `[127:96]`.
- `out_valid` out 1: block valid.
- `out_ready` in 1: consumer accepts block.
- `out_sop` out 1: block holds the packet's first word.
- `out_eop` out 1: block holds the packet's last word.
- `out_empty` out 4: empty low-order bytes of the block (0..15).
- `avs_address` in 32: MM byte address.
- `avs_read` in 1: MM read strobe.
- `avs_write` in 1: MM write strobe.
- `avs_writedata` in 32: MM write data (ignored; any write clears).
- `avs_readdata` out 32: MM read data.
- `avs_readdatavalid` out 1: read data valid.

## Operation
- Handshakes: an input word is accepted when `in_valid && in_ready`. A block is transferred when `out_valid && out_ready`.
- Ready rule: `in_ready = !out_valid || out_ready`. This is combinational, with no bubble between blocks.
- Packing:
  - A 2-bit word index `idx` selects the lane: word n goes to bits `[127-32n -: 32]`.
  - The first word of a block clears the unused lanes to zero.
  - `out_sop` latches the `in_sop` of the block's first word.
- Block close: the block closes on the accepted word with `idx==3`, or on any accepted `in_eop`.
  - On close, the next cycle has `out_valid=1` and `idx` returns to 0.
  - `out_eop = in_eop` of the closing word.
  - `out_empty = 4*(3-idx_at_close) + (in_eop ? in_empty : 0)`.
- Hold: while `out_valid && !out_ready`, `out_*` are stable and no word is accepted.
- Simultaneous output transfer and input accept: the block drains and the new word lands in lane 0 of a fresh block.
- Protocol error: `in_sop` accepted while `idx!=0` is treated as a continuation word and sets the sticky `err` bit. `in_sop` is not carried to `out_sop` in that case.
- Word counter:
  - Increments by 1 on every accepted input word and wraps 255→0.
  - Any `avs_write` to `CNT_ADDR` clears both the counter and `err`. A clear in the same cycle as an increment wins (result is 0).
- MM read:
  - At `CNT_ADDR` returns `{23'b0, err, cnt[7:0]}`.
  - Any other address returns 0.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sop=0`, `out_eop=0`, `out_empty=0`, `idx=0`, `cnt=0`, `err=0`, `avs_readdata=0`, `avs_readdatavalid=0`. `in_ready=1` after reset.
- Latency: closing word accepted in cycle N → `out_valid` high in N+1.
- Throughput: 1 block per 4 input cycles with `out_ready` held high.
- MM read: strobe in cycle N → `avs_readdata` and `avs_readdatavalid=1` in N+1 for one cycle. The counter value returned is the value at the end of cycle N.
- Reset mid-block discards the partial block and any pending output.

## Structure
- Add to `aes_top_pack`:
  - `AES_WORDS_PER_BLOCK = AES_DATA_WIDTH/MAC_STREAM_WIDTH`.
  - `MAC_EMPTY_WIDTH = 2`.
  - `AES_EMPTY_WIDTH = 4`.
  - A packed struct `aes_block_t {data, sop, eop, empty}`.
- The block uses the existing register constants.
- One sub-module is natural: `aes_word_counter`, which holds the counter, sticky `err`, and MM read/clear logic and is reusable for `ADDER_WORD_CNT`/`REMOVER_WORD_CNT`.

## Test plan
- 8-word packet `0x00000001..0x00000008`, SOP on word 1, EOP with `empty=0`, `out_ready=1` → two blocks: `0x00000001_00000002_00000003_00000004` (sop=1, eop=0, empty=0), then `…05_06_07_08` (sop=0, eop=1, empty=0). Counter reads 8.
- 5-word packet, EOP word `0xAABBCC00` with `empty=1` → second block `0xAABBCC00_00000000_00000000_00000000`, eop=1, `empty=13`.
- `out_ready` low for 10 cycles while the block is valid → `in_ready=0` and `out_*` stable. Release → transfer, with the next input word accepted in the same cycle.
- 260 single-word packets → counter reads 4 (wrap). MM write → read returns 0. Clear coincident with an accepted word → 0.
- SOP asserted on word 2 of a block → `err=1` in the read (`0x100 | cnt`), packing unaffected.
- Assert `rst_n` with 2 words buffered → all outputs return to reset values. The next packet packs from lane 0.

Source files
------------

// File: rtl/aes_stream_packer_pkg.sv
// Shared constants and types for the MAC-to-AES stream packer slice.
package aes_stream_packer_pkg;

  // Datapath widths
  localparam int MAC_STREAM_WIDTH    = 32;
  localparam int AES_DATA_WIDTH      = 128;
  localparam int WORD_COUNTER_SIZE   = 8;
  localparam int AES_WORDS_PER_BLOCK = AES_DATA_WIDTH / MAC_STREAM_WIDTH;
  localparam int MAC_EMPTY_WIDTH     = 2;
  localparam int AES_EMPTY_WIDTH     = 4;

  // Peripheral register map
  localparam logic [31:0] PERIPHERAL_ADDR  = 32'h0000_1000;
  localparam logic [31:0] MSG_WORD_CNT     = 32'h0000_0000;
  localparam logic [31:0] ADDER_WORD_CNT   = 32'h0000_0004;
  localparam logic [31:0] REMOVER_WORD_CNT = 32'h0000_0008;

  // One packed AES block plus its packet framing
  typedef struct packed {
    logic [AES_DATA_WIDTH-1:0]  data;
    logic                       sop;
    logic                       eop;
    logic [AES_EMPTY_WIDTH-1:0] empty;
  } aes_block_t;

endpackage

// File: rtl/aes_stream_packer_if.sv
// Stream-in, block-out and Avalon-MM signals of the stream packer.
interface aes_stream_packer_if;
  import aes_stream_packer_pkg::*;

  logic [MAC_STREAM_WIDTH-1:0] in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_sop;
  logic                        in_eop;
  logic [MAC_EMPTY_WIDTH-1:0]  in_empty;

  logic [AES_DATA_WIDTH-1:0]   out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_sop;
  logic                        out_eop;
  logic [AES_EMPTY_WIDTH-1:0]  out_empty;

  logic [31:0]                 avs_address;
  logic                        avs_read;
  logic                        avs_write;
  logic [31:0]                 avs_writedata;
  logic [31:0]                 avs_readdata;
  logic                        avs_readdatavalid;

  // Packer side
  modport slave (
    input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
           avs_address, avs_read, avs_write, avs_writedata,
    output in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
           avs_readdata, avs_readdatavalid
  );

  // Source/sink/host side
  modport master (
    output in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
           avs_address, avs_read, avs_write, avs_writedata,
    input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
           avs_readdata, avs_readdatavalid
  );

endinterface

// File: rtl/aes_stream_packer_word_counter.sv
// Accepted-word counter with sticky protocol-error flag and MM read/clear.
// Generic enough to back the adder/remover word counters as well.
module aes_word_counter
  import aes_stream_packer_pkg::*;
#(
  parameter int          CNT_WIDTH = WORD_COUNTER_SIZE,
  parameter logic [31:0] CNT_ADDR  = PERIPHERAL_ADDR + MSG_WORD_CNT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        err_set,
  input  logic [31:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid
);

  logic                 clear, hit_rd, err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign clear  = avs_write && (avs_address == CNT_ADDR);
  assign hit_rd = avs_read  && (avs_address == CNT_ADDR);

  // Next counter/error state; a clear beats a same-cycle increment or error
  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(inc);
    err_d = err_q || err_set;
    if (clear) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  // State registers and one-cycle read response (returns end-of-cycle value)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q             <= '0;
      err_q             <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      err_q             <= err_d;
      avs_readdatavalid <= avs_read;
      avs_readdata      <= hit_rd ? 32'({err_d, cnt_d}) : '0;
    end
  end

endmodule

// File: rtl/aes_stream_packer.sv
// Packs 32-bit MAC stream words four to a 128-bit AES block (first word in
// the top lane), zero-padding short final blocks and carrying SOP/EOP/empty.
module aes_stream_packer
  import aes_stream_packer_pkg::*;
#(
  parameter int          IN_WIDTH  = MAC_STREAM_WIDTH,
  parameter int          OUT_WIDTH = AES_DATA_WIDTH,
  parameter int          CNT_WIDTH = WORD_COUNTER_SIZE,
  parameter logic [31:0] CNT_ADDR  = PERIPHERAL_ADDR + MSG_WORD_CNT
) (
  input logic           clk,
  input logic           rst_n,
  aes_stream_packer_if.slave bus
);

  localparam int NUM_LANES = OUT_WIDTH / IN_WIDTH;
  localparam int IDX_W     = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LANES - 1);

  logic [IDX_W-1:0]           idx;
  logic [IN_WIDTH-1:0]        lane_q [NUM_LANES];
  logic [IN_WIDTH-1:0]        lane_d [NUM_LANES];
  logic                       out_valid_q, sop_q, eop_q;
  logic [AES_EMPTY_WIDTH-1:0] empty_q, empty_close;
  logic                       in_ready, acc, close, err_set;
  aes_block_t                 out_blk;
  logic                       unused_wdata;

  // Ready whenever the output slot is free or draining this cycle
  assign in_ready = !out_valid_q || bus.out_ready;
  assign acc      = bus.in_valid && in_ready;
  assign close    = acc && (bus.in_eop || idx == LAST);
  assign err_set  = acc && bus.in_sop && (idx != '0);

  // Empty bytes = unfilled lanes plus the EOP word's own empty bytes
  assign empty_close = AES_EMPTY_WIDTH'((NUM_LANES - 1 - int'(idx)) * (IN_WIDTH / 8))
                     + (bus.in_eop ? AES_EMPTY_WIDTH'(bus.in_empty) : '0);

  // Per-lane next value: load on its own index, zero on a block's first word
  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    assign lane_d[n] = (acc && idx == IDX_W'(n)) ? bus.in_data :
                       (acc && idx == '0)        ? '0          : lane_q[n];
  end

  // Lane storage; the block is built in place since no word is accepted
  // while a finished block is waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_LANES; n++) lane_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_LANES; n++) lane_q[n] <= lane_d[n];
    end
  end

  // Lane index, block framing and output-valid tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      out_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= '0;
    end else begin
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (acc) begin
        if (idx == '0) begin
          sop_q   <= bus.in_sop;
          eop_q   <= 1'b0;
          empty_q <= '0;
        end
        if (close) begin
          out_valid_q <= 1'b1;
          idx         <= '0;
          eop_q       <= bus.in_eop;
          empty_q     <= empty_close;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Assemble the outgoing block, word 0 in the most significant lane
  always_comb begin
    out_blk = '0;
    for (int n = 0; n < NUM_LANES; n++)
      out_blk.data[OUT_WIDTH-1-n*IN_WIDTH -: IN_WIDTH] = lane_q[n];
    out_blk.sop   = sop_q;
    out_blk.eop   = eop_q;
    out_blk.empty = empty_q;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_blk.data;
  assign bus.out_sop   = out_blk.sop;
  assign bus.out_eop   = out_blk.eop;
  assign bus.out_empty = out_blk.empty;

  // Write data is irrelevant: any write to the counter address clears it
  assign unused_wdata = ^bus.avs_writedata;

  aes_word_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .CNT_ADDR  (CNT_ADDR)
  ) u_cnt (
    .clk               (clk),
    .rst_n             (rst_n),
    .inc               (acc),
    .err_set           (err_set),
    .avs_address       (bus.avs_address),
    .avs_read          (bus.avs_read),
    .avs_write         (bus.avs_write),
    .avs_readdata      (bus.avs_readdata),
    .avs_readdatavalid (bus.avs_readdatavalid)
  );

endmodule

// File: tb/tb_aes_stream_packer.sv
// Directed bench for aes_stream_packer with a word-list packet model and a
// per-cycle compare process on the falling edge.
module tb_aes_stream_packer;
  import aes_stream_packer_pkg::*;

  localparam logic [31:0] CA = PERIPHERAL_ADDR + MSG_WORD_CNT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_stream_packer_if bus();

  aes_stream_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  aes_block_t  exp_q[$];
  aes_block_t  obs_q[$];
  logic [31:0] cur_w[$];
  logic        cur_sop;
  int unsigned cnt_m;
  logic        err_m;
  logic        close_pend, hold_vld, clr_m;
  aes_block_t  hold_blk, m_e, m_b, dut_blk;

  assign dut_blk = {bus.out_data, bus.out_sop, bus.out_eop, bus.out_empty};

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  // Compare process: model the packet rules and check outputs every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); cur_w.delete();
      cnt_m = 0; err_m = 1'b0; close_pend = 1'b0; hold_vld = 1'b0;
    end else begin
      if (close_pend) chk("latency out_valid", bus.out_valid, 1);
      close_pend = 1'b0;
      if (!bus.out_valid) chk("in_ready idle", bus.in_ready, 1);
      if (bus.out_valid && !bus.out_ready) chk("in_ready hold", bus.in_ready, 0);
      if (hold_vld) begin
        chk("hold data", bus.out_data, hold_blk.data);
        chk("hold ctl", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_empty},
            {1'b1, hold_blk.sop, hold_blk.eop, hold_blk.empty});
      end
      hold_vld = bus.out_valid && !bus.out_ready;
      hold_blk = dut_blk;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected block: got %h want none", bus.out_data);
        end else begin
          m_e = exp_q.pop_front();
          chk("block data", bus.out_data, m_e.data);
          chk("block sop/eop/empty", {bus.out_sop, bus.out_eop, bus.out_empty},
              {m_e.sop, m_e.eop, m_e.empty});
        end
        obs_q.push_back(dut_blk);
      end
      clr_m = bus.avs_write && (bus.avs_address == CA);
      if (bus.in_valid && bus.in_ready) begin
        if (cur_w.size() == 0) cur_sop = bus.in_sop;
        else if (bus.in_sop) err_m = 1'b1;
        cur_w.push_back(bus.in_data);
        if (bus.in_eop || cur_w.size() == 4) begin
          m_b = '0;
          for (int i = 0; i < cur_w.size(); i++) m_b.data[127-32*i -: 32] = cur_w[i];
          m_b.sop   = cur_sop;
          m_b.eop   = bus.in_eop;
          m_b.empty = 4'(4 * (4 - cur_w.size()) + (bus.in_eop ? int'(bus.in_empty) : 0));
          exp_q.push_back(m_b);
          cur_w.delete();
          close_pend = 1'b1;
        end
        cnt_m = (cnt_m + 1) % 256;
      end
      if (clr_m) begin cnt_m = 0; err_m = 1'b0; end
    end
  end

  task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    int t;
    t = 0;
    bus.in_data = d; bus.in_sop = s; bus.in_eop = e; bus.in_empty = em; bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 50) begin
        n_cmp++; n_bad++;
        $display("FAIL send timeout: in_ready stuck 0 for word %h", d);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.in_empty = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mm_write();
    bus.avs_address = CA; bus.avs_write = 1'b1;
    @(posedge clk); #1;
    bus.avs_write = 1'b0;
  endtask

  task automatic mm_read(input logic [31:0] a, input logic [31:0] lit, input string nm);
    logic [31:0] ex;
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(posedge clk); #1;
    bus.avs_read = 1'b0;
    @(negedge clk);
    ex = (a == CA) ? {23'b0, err_m, cnt_m[7:0]} : 32'h0;
    chk({nm, " rdvalid"}, bus.avs_readdatavalid, 1);
    chk({nm, " vs model"}, bus.avs_readdata, ex);
    chk({nm, " literal"}, bus.avs_readdata, lit);
    @(posedge clk); #1;
  endtask

  task automatic check_obs(input string nm, input logic [127:0] d, input logic s,
                           input logic e, input logic [3:0] em);
    aes_block_t b;
    if (obs_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got no block want %h", nm, d);
    end else begin
      b = obs_q.pop_front();
      chk({nm, " data"}, b.data, d);
      chk({nm, " ctl"}, {b.sop, b.eop, b.empty}, {s, e, em});
    end
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " out_valid"}, bus.out_valid, 0);
    chk({nm, " out_data"}, bus.out_data, 0);
    chk({nm, " sop/eop/empty"}, {bus.out_sop, bus.out_eop, bus.out_empty}, 0);
    chk({nm, " in_ready"}, bus.in_ready, 1);
    chk({nm, " readdata"}, {bus.avs_readdatavalid, bus.avs_readdata}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    bus.in_empty = '0; bus.out_ready = 1'b1; bus.avs_address = '0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // 8-word packet -> two full blocks
    for (int i = 1; i <= 8; i++) send(32'(i), i == 1, i == 8, 2'd0);
    idle(3);
    check_obs("pkt8 blk0", 128'h00000001_00000002_00000003_00000004, 1, 0, 4'd0);
    check_obs("pkt8 blk1", 128'h00000005_00000006_00000007_00000008, 0, 1, 4'd0);
    mm_read(CA, 32'd8, "cnt after pkt8");

    // 5-word packet, short tail with empty=1
    for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), i == 0, 1'b0, 2'd0);
    send(32'hAABBCC00, 1'b0, 1'b1, 2'd1);
    idle(3);
    check_obs("pkt5 blk0", 128'h00000010_00000011_00000012_00000013, 1, 0, 4'd0);
    check_obs("pkt5 blk1", 128'hAABBCC00_00000000_00000000_00000000, 0, 1, 4'd13);
    mm_read(CA, 32'd13, "cnt after pkt5");

    // Back-pressure for 10 cycles with a word waiting, then release
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h21 + 32'(i), i == 0, 1'b0, 2'd0);
    bus.in_data = 32'h25; bus.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("stall in_ready", bus.in_ready, 0);
    chk("stall out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    send(32'h26, 1'b0, 1'b0, 2'd0);
    send(32'h27, 1'b0, 1'b0, 2'd0);
    send(32'h28, 1'b0, 1'b1, 2'd0);
    idle(3);
    check_obs("stall blk0", 128'h00000021_00000022_00000023_00000024, 1, 0, 4'd0);
    check_obs("stall blk1", 128'h00000025_00000026_00000027_00000028, 0, 1, 4'd0);
    mm_read(CA, 32'd21, "cnt after stall");

    // Counter wrap over 260 single-word packets, then clears
    mm_write();
    for (int i = 0; i < 260; i++) send(32'h100 + 32'(i), 1'b1, 1'b1, 2'd0);
    idle(3);
    check_obs("single blk0", 128'h00000100_00000000_00000000_00000000, 1, 1, 4'd12);
    obs_q.delete();
    mm_read(CA, 32'd4, "cnt wrap");
    mm_write();
    mm_read(CA, 32'd0, "cnt after clear");
    bus.in_data = 32'h77; bus.in_sop = 1'b1; bus.in_eop = 1'b1; bus.in_valid = 1'b1;
    bus.avs_address = CA; bus.avs_write = 1'b1;
    @(negedge clk);
    chk("coincident in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.avs_write = 1'b0;
    idle(2);
    mm_read(CA, 32'd0, "cnt clear wins");
    mm_read(32'h0000_2000, 32'd0, "other addr");

    // SOP on the second word sets err but does not disturb packing
    obs_q.delete();
    mm_write();
    send(32'h31, 1'b1, 1'b0, 2'd0);
    send(32'h32, 1'b1, 1'b0, 2'd0);
    send(32'h33, 1'b0, 1'b0, 2'd0);
    send(32'h34, 1'b0, 1'b1, 2'd0);
    idle(3);
    check_obs("err blk", 128'h00000031_00000032_00000033_00000034, 1, 1, 4'd0);
    mm_read(CA, 32'h104, "err read");

    // Reset with two words buffered
    send(32'h41, 1'b1, 1'b0, 2'd0);
    send(32'h42, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("mid reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    obs_q.delete();
    for (int i = 0; i < 4; i++) send(32'h51 + 32'(i), i == 0, i == 3, 2'd0);
    idle(3);
    check_obs("post reset blk", 128'h00000051_00000052_00000053_00000054, 1, 1, 4'd0);
    chk("post reset block count", 128'(obs_q.size()), 0);
    mm_read(CA, 32'd4, "cnt after reset");
    chk("model drained", 128'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
